// File: rtl/pipelined_sub_borrow_128.sv
// pipelined_sub_borrow_128
//   Two-stage pipelined subtractor: diff = a - b - bin (mod 2^WIDTH), with
//   borrow-out and a zero flag. Each segment is resolved by a parallel-prefix
//   carry tree on a + ~b + ~bin. Stage 1 resolves the low SPLIT bits and
//   registers the low-segment borrow. Stage 2 resolves the high bits from that
//   borrow and registers the full result.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, bin)
//   out_valid / out_ready result handshake (diff, bout, zero)
//   diff                 (a - b - bin) mod 2^WIDTH
//   bout                 1 when a < b + bin (unsigned)
//   zero                 1 when diff == 0
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. in_ready depends on out_ready and pipeline state only, never on
// in_valid. When out_valid=1 and out_ready=0, the outputs hold their values.

// Kogge-Stone style adder segment: o_sum = i_x + i_y + i_cin.
// The carry-in is treated as an extra generate bit below bit 0. After the
// prefix levels, g[i] is the carry into original bit i. g[N] is the carry-out.
module pipelined_sub_borrow_128_pfx #(
    parameter int N = 64
) (
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    localparam int L = $clog2(N + 1);

    logic [N:0] w_g;
    logic [N:0] w_p;
    logic [N:0] w_g_n;
    logic [N:0] w_p_n;

    always_comb begin
        w_g   = {i_x & i_y, i_cin};
        w_p   = {i_x ^ i_y, 1'b0};
        w_g_n = '0;
        w_p_n = '0;
        for (int k = 0; k < L; k++) begin
            for (int i = 0; i <= N; i++) begin
                if (i >= (1 << k)) begin
                    w_g_n[i] = w_g[i] | (w_p[i] & w_g[i - (1 << k)]);
                    w_p_n[i] = w_p[i] & w_p[i - (1 << k)];
                end else begin
                    w_g_n[i] = w_g[i];
                    w_p_n[i] = w_p[i];
                end
            end
            w_g = w_g_n;
            w_p = w_p_n;
        end
    end

    assign o_sum  = (i_x ^ i_y) ^ w_g[N-1:0];
    assign o_cout = w_g[N];
endmodule

module pipelined_sub_borrow_128 #(
    parameter int WIDTH = 128,
    parameter int SPLIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int HI = WIDTH - SPLIT;

    logic                r_s1_valid;
    logic [SPLIT-1:0]    r_s1_lo;
    logic                r_s1_brw;
    logic [HI-1:0]       r_s1_a_hi;
    logic [HI-1:0]       r_s1_b_hi;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_diff;
    logic                r_bout;
    logic                r_zero;

    logic                w_s2_adv;
    logic                w_accept;
    logic [SPLIT-1:0]    w_lo_sum;
    logic                w_lo_cout;
    logic [HI-1:0]       w_hi_sum;
    logic                w_hi_cout;
    logic [WIDTH-1:0]    w_full;

    // Stage 2 loads when it is empty or when its result leaves this cycle.
    assign w_s2_adv = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready = ~r_s1_valid | w_s2_adv;
    assign w_accept = in_valid & in_ready;

    // Subtraction as a + ~b + ~bin. A carry-out of 1 means no borrow.
    pipelined_sub_borrow_128_pfx #(.N(SPLIT)) u_lo (
        .i_x    (a[SPLIT-1:0]),
        .i_y    (~b[SPLIT-1:0]),
        .i_cin  (~bin),
        .o_sum  (w_lo_sum),
        .o_cout (w_lo_cout)
    );

    pipelined_sub_borrow_128_pfx #(.N(HI)) u_hi (
        .i_x    (r_s1_a_hi),
        .i_y    (~r_s1_b_hi),
        .i_cin  (~r_s1_brw),
        .o_sum  (w_hi_sum),
        .o_cout (w_hi_cout)
    );

    assign w_full = {w_hi_sum, r_s1_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_lo     <= '0;
            r_s1_brw    <= 1'b0;
            r_s1_a_hi   <= '0;
            r_s1_b_hi   <= '0;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_lo   <= w_lo_sum;
                r_s1_brw  <= ~w_lo_cout;
                r_s1_a_hi <= a[WIDTH-1:SPLIT];
                r_s1_b_hi <= b[WIDTH-1:SPLIT];
            end
            r_s1_valid <= w_accept | (r_s1_valid & ~w_s2_adv);

            if (w_s2_adv) begin
                r_diff      <= w_full;
                r_bout      <= ~w_hi_cout;
                r_zero      <= (w_full == '0);
                r_out_valid <= 1'b1;
            end else if (r_out_valid & out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign zero      = r_zero;
endmodule
